ina_sample_filter: RTL

//   Downstream consumer of the INA219 I2C reader's 16-bit result register.
//   - Samples the register on a fixed period and rejects torn reads: the register

---
 rtl/ina_sample_filter.sv | 178 +++++++++++++++++
 1 files changed

// File: rtl/ina_sample_filter.sv
// Purpose : filters the INA219 result register. A read counts only if two consecutive reads agree (torn-read rejection).
//           Accepted reads are averaged over 2^LOG2_N samples, with window min/max and an alarm that has hysteresis.
// Latency : avg_valid is high 4 cycles after the tick that took the last sample of a window, when there are no retries.
// Backpressure: none. Results are published as a one-cycle pulse and are held until the next window completes.
//
// Ports:
//   clk        50 MHz system clock
//   reset      asynchronous reset, active low
//   raw_data   signed 16-bit INA219 register value (quasi-static, written from the I2C side)
//   avg_out    signed window average (rounds toward -inf)
//   min_out    signed minimum of the last completed window
//   max_out    signed maximum of the last completed window
//   avg_valid  one-cycle pulse; avg_out/min_out/max_out/alarm change together with it
//   alarm      over-threshold flag with hysteresis
//   err_cnt    count of discarded unstable samples, saturating at 255
module ina_sample_filter #(
    parameter int                 SAMPLE_DIV = 500000,
    parameter int                 LOG2_N     = 4,
    parameter logic signed [15:0] ALARM_TH   = 16'sd3200,
    parameter logic signed [15:0] ALARM_HYST = 16'sd160
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [15:0] raw_data,
    output logic [15:0] avg_out,
    output logic [15:0] min_out,
    output logic [15:0] max_out,
    output logic        avg_valid,
    output logic        alarm,
    output logic [7:0]  err_cnt
);

    localparam int TW = $clog2(SAMPLE_DIV);
    localparam int AW = 16 + LOG2_N;

    localparam logic [2:0] S_WAIT    = 3'd0;
    localparam logic [2:0] S_CAP     = 3'd1;
    localparam logic [2:0] S_CHECK   = 3'd2;
    localparam logic [2:0] S_ACCUM   = 3'd3;
    localparam logic [2:0] S_PUBLISH = 3'd4;

    // Thresholds are widened to 17 bits so that ALARM_TH - ALARM_HYST cannot wrap.
    localparam logic signed [16:0] TH_HI = $signed({ALARM_TH[15], ALARM_TH});
    localparam logic signed [16:0] TH_LO = TH_HI - $signed({ALARM_HYST[15], ALARM_HYST});

    logic [TW-1:0]          r_tick_cnt;
    logic [2:0]             r_state;
    logic [15:0]            r_cap;
    logic [1:0]             r_retry;
    logic signed [AW-1:0]   r_acc;
    logic [LOG2_N-1:0]      r_n;
    logic signed [15:0]     r_wmin;
    logic signed [15:0]     r_wmax;
    logic signed [15:0]     r_avg;
    logic signed [15:0]     r_min;
    logic signed [15:0]     r_max;
    logic                   r_avg_valid;
    logic                   r_alarm;
    logic [7:0]             r_err_cnt;

    logic                   w_tick;
    logic                   w_last;
    logic signed [15:0]     w_cap_s;
    logic signed [AW-1:0]   w_acc_nxt;
    logic signed [15:0]     w_min_nxt;
    logic signed [15:0]     w_max_nxt;
    logic signed [15:0]     w_avg_nxt;
    logic signed [16:0]     w_avg_ext;

    assign w_tick  = (r_tick_cnt == TW'(SAMPLE_DIV - 1));
    assign w_last  = (r_n == {LOG2_N{1'b1}});
    assign w_cap_s = r_cap;

    // Window state after the sample in ACCUM has been folded in. The outputs are
    // loaded from these values in ACCUM. This makes new data visible in the same
    // cycle as the avg_valid pulse, which is high while the FSM sits in PUBLISH.
    assign w_acc_nxt = r_acc + {{LOG2_N{r_cap[15]}}, r_cap};
    assign w_min_nxt = (w_cap_s < r_wmin) ? w_cap_s : r_wmin;
    assign w_max_nxt = (w_cap_s > r_wmax) ? w_cap_s : r_wmax;
    assign w_avg_nxt = 16'(w_acc_nxt >>> LOG2_N);
    assign w_avg_ext = {w_avg_nxt[15], w_avg_nxt};

    // Free-running sample period counter. The FSM never stalls it.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_tick_cnt <= '0;
        end else if (w_tick) begin
            r_tick_cnt <= '0;
        end else begin
            r_tick_cnt <= r_tick_cnt + 1'b1;
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_state     <= S_WAIT;
            r_cap       <= '0;
            r_retry     <= '0;
            r_acc       <= '0;
            r_n         <= '0;
            r_wmin      <= 16'sh7FFF;
            r_wmax      <= 16'sh8000;
            r_avg       <= '0;
            r_min       <= '0;
            r_max       <= '0;
            r_avg_valid <= 1'b0;
            r_alarm     <= 1'b0;
            r_err_cnt   <= '0;
        end else begin
            r_avg_valid <= 1'b0;
            case (r_state)
                S_WAIT: begin
                    // Ticks are only honoured here. With SAMPLE_DIV >= 8 the FSM
                    // is always back in WAIT before the next tick arrives.
                    if (w_tick) begin
                        r_state <= S_CAP;
                    end
                end
                S_CAP: begin
                    r_cap   <= raw_data;
                    r_retry <= '0;
                    r_state <= S_CHECK;
                end
                S_CHECK: begin
                    if (raw_data == r_cap) begin
                        r_state <= S_ACCUM;
                    end else if (r_retry == 2'd2) begin
                        if (r_err_cnt != 8'hFF) begin
                            r_err_cnt <= r_err_cnt + 1'b1;
                        end
                        r_state <= S_WAIT;
                    end else begin
                        r_cap   <= raw_data;
                        r_retry <= r_retry + 1'b1;
                    end
                end
                S_ACCUM: begin
                    r_acc  <= w_acc_nxt;
                    r_wmin <= w_min_nxt;
                    r_wmax <= w_max_nxt;
                    r_n    <= r_n + 1'b1;
                    if (w_last) begin
                        r_avg       <= w_avg_nxt;
                        r_min       <= w_min_nxt;
                        r_max       <= w_max_nxt;
                        r_avg_valid <= 1'b1;
                        if (w_avg_ext > TH_HI) begin
                            r_alarm <= 1'b1;
                        end else if (w_avg_ext <= TH_LO) begin
                            r_alarm <= 1'b0;
                        end
                        r_state <= S_PUBLISH;
                    end else begin
                        r_state <= S_WAIT;
                    end
                end
                S_PUBLISH: begin
                    r_acc   <= '0;
                    r_n     <= '0;
                    r_wmin  <= 16'sh7FFF;
                    r_wmax  <= 16'sh8000;
                    r_state <= S_WAIT;
                end
                default: begin
                    r_state <= S_WAIT;
                end
            endcase
        end
    end

    assign avg_out   = r_avg;
    assign min_out   = r_min;
    assign max_out   = r_max;
    assign avg_valid = r_avg_valid;
    assign alarm     = r_alarm;
    assign err_cnt   = r_err_cnt;

endmodule
